data_sram_ctrl: RTL and testbench
=================================

DATA_SRAM_CTRL -- requirements
Module: data_sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning byte-address width; memory holds 2**ADDR_W bytes.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, legal range 0..15, meaning wait states inserted before each access.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_valid input 1 and req_ready output 1, the request handshake.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-009 SHALL have port req_addr  input  32  byte address, little-endian.
REQ-010 SHALL have port req_wdata  input  32  store data, low bytes used.
REQ-011 SHALL have ports rsp_valid output 1 and rsp_ready input 1, the response handshake.
REQ-012 SHALL have port rsp_rdata  output  32  load result, extended.
REQ-013 SHALL have port rsp_err  output  1  access rejected.
REQ-014 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACCESS and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE and SHALL accept a request on an edge where req_valid && req_ready.
REQ-017 SHALL register all request fields on acceptance; input changes after acceptance SHALL have no effect.
REQ-018 SHALL transition IDLE->WAIT on acceptance, or IDLE->ACCESS when WAIT_CYCLES=0; WAIT SHALL last exactly WAIT_CYCLES cycles and then go to ACCESS.
REQ-019 ACCESS SHALL last one cycle; stores SHALL commit and load data SHALL be captured on the ACCESS->RESP edge.
REQ-020 RESP SHALL hold rsp_valid=1 with stable rsp_rdata and rsp_err until rsp_ready=1, then return to IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-021 Latency: if the request is accepted at edge E, rsp_valid SHALL first be high after edge E+WAIT_CYCLES+1.
REQ-022 Byte i of an access SHALL map to mem[(addr+i) mod 2**ADDR_W]; byte 0 SHALL be the LSB.
REQ-023 Loads: a byte load SHALL extend bit 7 and a half load SHALL extend bit 15, each per req_unsigned; a word load SHALL be unchanged.
REQ-024 Store data: a byte store SHALL use wdata[7:0] and a half store SHALL use wdata[15:0]; all other memory bytes SHALL be untouched.
REQ-025 Error if req_size=11 or req_addr[31:ADDR_W]!=0; on error there SHALL be no memory write, rsp_rdata=0 and rsp_err=1.
REQ-026 For non-error responses, rsp_err SHALL be 0; rsp_rdata SHALL be 0 for stores.
REQ-027 Outside RESP, rsp_rdata SHALL be 0 and rsp_err SHALL be 0.

Reset
REQ-028 rst SHALL force the IDLE state and clear the wait counter and all response registers immediately.
REQ-029 Reset values SHALL be: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
REQ-030 Reset asserted in WAIT or ACCESS before the commit edge SHALL abort the request with no memory write and no response.
REQ-031 Memory contents SHALL NOT be initialised or cleared by reset.

Configuration
REQ-032 Macro MISALIGN_TRAP_EN defined: a half access with addr[0]!=0, or a word access with addr[1:0]!=0, SHALL be an error per REQ-025.
REQ-033 Macro MISALIGN_TRAP_EN undefined: misaligned accesses SHALL complete byte-wise per REQ-022, including wrap past the top address, with no error.

Verification
REQ-034 WAIT_CYCLES=1: store word 0xDEADBEEF to 0x10, then load word from 0x10 -> rdata=0xDEADBEEF; rsp_valid first high 2 edges after each acceptance.
REQ-035 After REQ-034: signed byte load from 0x13 -> 0xFFFFFFDE; unsigned half load from 0x12 -> 0x0000DEAD; signed half load from 0x10 -> 0xFFFFBEEF.
REQ-036 Byte store 0x55 to 0x11 over 0xDEADBEEF -> word load from 0x10 returns 0xDEAD55EF.
REQ-037 Load from 0x00010000 with ADDR_W=16, and any access with size=11 -> rsp_err=1, rdata=0, memory unchanged.
REQ-038 Word store 0x11223344 to 0xFFFF: with MISALIGN_TRAP_EN -> rsp_err=1, no write; without -> mem[0xFFFF]=0x44 and mem[0x0000..0x0002]=0x33,0x22,0x11.
REQ-039 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0; assert rst during WAIT of a store -> target bytes unchanged, rsp_valid=0, req_ready=1.

Source files
------------

// File: rtl/data_sram_if.sv
// data_sram_if: request/response bus between a client and the data SRAM controller
interface data_sram_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl: byte-addressed SRAM with wait states, sized/extended loads and stores; MISALIGN_TRAP_EN traps misaligned half/word accesses
module data_sram_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    data_sram_if.slave  bus,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
    state_t st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic rerr_q, rerr_d;
    logic we_q, uns_q, bad_q;
    logic [1:0] size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] a [4];
    logic [31:0] word, ld;
    logic acc, mis, bad, wr;
`ifdef MISALIGN_TRAP_EN
    assign mis = (bus.req_size == 2'd1 && bus.req_addr[0]) || (bus.req_size == 2'd2 && |bus.req_addr[1:0]);
`else
    assign mis = 1'b0;
`endif
    assign acc = st_q == IDLE && bus.req_valid;
    assign bad = bus.req_size == 2'd3 || (bus.req_addr >> ADDR_W) != 32'd0 || mis;
    assign wr = st_q == ACCESS && we_q && !bad_q && !rst;
    // Byte lane addresses wrap modulo the memory size
    always_comb begin
        for (int k = 0; k < 4; k++) a[k] = addr_q + ADDR_W'(k);
    end
    assign word = {mem[a[3]], mem[a[2]], mem[a[1]], mem[a[0]]};
    assign ld = size_q == 2'd0 ? {{24{~uns_q & word[7]}}, word[7:0]} :
                size_q == 2'd1 ? {{16{~uns_q & word[15]}}, word[15:0]} : word;
    // Next-state and response register logic
    always_comb begin
        st_d = st_q;
        cnt_d = cnt_q;
        rdata_d = rdata_q;
        rerr_d = rerr_q;
        case (st_q)
            IDLE: if (acc) begin
                st_d = WAIT_CYCLES == 0 ? ACCESS : WAIT;
                cnt_d = WAIT_LD;
            end
            WAIT: if (cnt_q == 4'd0) st_d = ACCESS; else cnt_d = cnt_q - 4'd1;
            ACCESS: begin
                st_d = RESP;
                rdata_d = (bad_q || we_q) ? 32'd0 : ld;
                rerr_d = bad_q;
            end
            default: if (bus.rsp_ready) begin
                st_d = IDLE;
                rdata_d = 32'd0;
                rerr_d = 1'b0;
            end
        endcase
    end
    // State, counter and response registers; request fields latched on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= IDLE;
            cnt_q <= 4'd0;
            rdata_q <= 32'd0;
            rerr_q <= 1'b0;
            we_q <= 1'b0;
            uns_q <= 1'b0;
            bad_q <= 1'b0;
            size_q <= 2'd0;
            addr_q <= '0;
            wdata_q <= 32'd0;
        end else begin
            st_q <= st_d;
            cnt_q <= cnt_d;
            rdata_q <= rdata_d;
            rerr_q <= rerr_d;
            if (acc) begin
                we_q <= bus.req_we;
                uns_q <= bus.req_unsigned;
                bad_q <= bad;
                size_q <= bus.req_size;
                addr_q <= bus.req_addr[ADDR_W-1:0];
                wdata_q <= bus.req_wdata;
            end
        end
    end
    // Store commit on the ACCESS->RESP edge; memory is never reset
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[a[0]] <= wdata_q[7:0];
            if (size_q != 2'd0) mem[a[1]] <= wdata_q[15:8];
            if (size_q == 2'd2) begin
                mem[a[2]] <= wdata_q[23:16];
                mem[a[3]] <= wdata_q[31:24];
            end
        end
    end
    assign bus.req_ready = st_q == IDLE;
    assign bus.rsp_valid = st_q == RESP;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err = rerr_q;
    assign busy = st_q != IDLE;
endmodule

// File: tb/tb_data_sram_ctrl.sv
// tb_data_sram_ctrl: directed test of data_sram_ctrl against a byte-array reference model
module tb_data_sram_ctrl;
    localparam int W = 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    always #5 clk = ~clk;
    data_sram_if bus();
    data_sram_ctrl #(.ADDR_W(16), .WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));
    typedef struct packed {logic [31:0] rd; logic err;} rsp_t;
    rsp_t exp_q[$];
    logic [7:0] mm [int];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit waiting = 0;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic rsp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] ad, input logic [31:0] wd);
        rsp_t r;
        int n;
        logic [31:0] v;
        n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        r.err = sz == 2'd3 || ad >= 32'h10000 ||
                (TRAP && ((sz == 2'd1 && ad % 2 != 0) || (sz == 2'd2 && ad % 4 != 0)));
        r.rd = 32'd0;
        if (!r.err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mm[int'((ad + 32'(i)) & 32'hFFFF)] = 8'(wd >> (8 * i));
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(mm[int'((ad + 32'(i)) & 32'hFFFF)]) << (8 * i));
                if (n < 4 && !uns && v[8 * n - 1]) v = v | (32'hFFFFFFFF << (8 * n));
                r.rd = v;
            end
        end
        return r;
    endfunction

    // Per-cycle comparison of DUT outputs against the model's expected responses
    always @(negedge clk) begin
        if (rst) begin
            waiting = 0;
            chk("rst_req_ready", bus.req_ready, 1);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_rdata", bus.rsp_rdata, 0);
            chk("rst_rsp_err", bus.rsp_err, 0);
            chk("rst_busy", busy, 0);
        end else begin
            chk("ready_vs_busy", bus.req_ready, !busy);
            if (waiting && !bus.rsp_valid) chk("busy_in_flight", busy, 1);
            if (bus.req_valid && bus.req_ready) begin
                waiting = 1;
                acc_cyc = cyc;
            end
            if (bus.rsp_valid) begin
                if (waiting) begin
                    chk("latency", cyc - acc_cyc, W + 2);
                    waiting = 0;
                end
                chk("resp_req_ready", bus.req_ready, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", bus.rsp_valid, 0);
                end else begin
                    chk("rsp_rdata", bus.rsp_rdata, exp_q[0].rd);
                    chk("rsp_err", bus.rsp_err, exp_q[0].err);
                    if (bus.rsp_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_rdata", bus.rsp_rdata, 0);
                chk("idle_err", bus.rsp_err, 0);
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] ad,
                          input logic [31:0] wd, input int hold, input logic [31:0] lit_rd, input logic lit_err);
        exp_q.push_back(model(we, sz, uns, ad, wd));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = sz;
        bus.req_unsigned = uns;
        bus.req_addr = ad;
        bus.req_wdata = wd;
        @(negedge clk);
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we = ~we;
        bus.req_size = 2'($urandom);
        bus.req_unsigned = ~uns;
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        @(negedge clk);
        for (int i = 0; i < 40 && !bus.rsp_valid; i++) @(negedge clk);
        if (!bus.rsp_valid) begin
            chk("rsp_timeout", bus.rsp_valid, 1);
            exp_q.delete();
            return;
        end
        repeat (hold) @(negedge clk);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("lit_rdata", bus.rsp_rdata, lit_rd);
        chk("lit_err", bus.rsp_err, lit_err);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic abort_store(input logic [31:0] ad, input logic [31:0] wd);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr = ad;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0);
        do_req(0, 2'd0, 0, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 0);
        do_req(0, 2'd1, 1, 32'h12, 32'h0, 0, 32'h0000DEAD, 0);
        do_req(0, 2'd1, 0, 32'h10, 32'h0, 0, 32'hFFFFBEEF, 0);
        do_req(1, 2'd0, 0, 32'h11, 32'hAAAABB55, 1, 32'h0, 0);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 5, 32'hDEAD55EF, 0);
        do_req(0, 2'd2, 0, 32'h00010000, 32'h0, 0, 32'h0, 1);
        do_req(1, 2'd3, 0, 32'h10, 32'h12345678, 0, 32'h0, 1);
        do_req(0, 2'd3, 1, 32'h10, 32'h0, 0, 32'h0, 1);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 0, 32'hDEAD55EF, 0);
        do_req(1, 2'd1, 0, 32'h40, 32'h123480FF, 0, 32'h0, 0);
        do_req(0, 2'd0, 0, 32'h40, 32'h0, 0, 32'hFFFFFFFF, 0);
        do_req(0, 2'd0, 1, 32'h41, 32'h0, 0, 32'h00000080, 0);
        do_req(0, 2'd1, 1, 32'h40, 32'h0, 0, 32'h000080FF, 0);
        do_req(0, 2'd1, 0, 32'h40, 32'h0, 2, 32'hFFFF80FF, 0);
        do_req(1, 2'd0, 0, 32'hFFFF, 32'h77, 0, 32'h0, 0);
        do_req(1, 2'd2, 0, 32'hFFFF, 32'h11223344, 0, 32'h0, TRAP);
        do_req(0, 2'd0, 1, 32'hFFFF, 32'h0, 0, TRAP ? 32'h77 : 32'h44, 0);
        do_req(0, 2'd2, 0, 32'hFFFF, 32'h0, 0, TRAP ? 32'h0 : 32'h11223344, TRAP);
        do_req(0, 2'd1, 1, 32'h0001, 32'h0, 0, TRAP ? 32'h0 : 32'h00001122, TRAP);
        do_req(1, 2'd2, 0, 32'h20, 32'h01020304, 0, 32'h0, 0);
        abort_store(32'h20, 32'hA5A5A5A5);
        do_req(0, 2'd2, 0, 32'h20, 32'h0, 0, 32'h01020304, 0);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
